// File: rtl/v_asymmetric_byte_packer_pkg.sv
// Shared constants, log2 helper and FSM state encoding for the asymmetric byte packer.
package v_asymmetric_byte_packer_pkg;

  function automatic int unsigned log2(input int unsigned value);
    int unsigned shifted;
    int unsigned res;
    if (value < 2) return value;
    shifted = value - 1;
    res = 0;
    while (shifted > 0) begin
      shifted = shifted >> 1;
      res++;
    end
    return res;
  endfunction

  // Values for the default 8-bit / 32-bit RAM pairing
  localparam int unsigned RATIO = 32 / 8;
  localparam int unsigned LANEW = log2(RATIO);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

endpackage

// File: rtl/v_asymmetric_byte_packer_lane_accum.sv
// Lane counter and accumulator: collects narrow bytes and presents the packed, PAD-filled word.
module v_asym_lane_accum
  import v_asymmetric_byte_packer_pkg::*;
#(
  parameter int unsigned       WIDTHA = 8,
  parameter int unsigned       WIDTHB = 32,
  parameter logic [WIDTHA-1:0] PAD    = '0
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              accept,
  input  logic              last,
  input  logic [WIDTHA-1:0] data,
  output logic              commit,
  output logic [WIDTHB-1:0] word
);

  localparam int unsigned NLANES = WIDTHB / WIDTHA;
  localparam int unsigned LW     = log2(NLANES);

  logic [LW-1:0]     lane;
  logic [WIDTHB-1:0] acc;

  always_comb begin
    commit = accept & (last | (lane == LW'(NLANES - 1)));
  end

  // The byte being accepted goes straight into the output word so a commit needs no extra cycle
  always_comb begin
    word = '0;
    for (int unsigned i = 0; i < NLANES; i++) begin
      if (i < 32'(lane))
        word[i*WIDTHA +: WIDTHA] = acc[i*WIDTHA +: WIDTHA];
      else if (i == 32'(lane))
        word[i*WIDTHA +: WIDTHA] = data;
      else
        word[i*WIDTHA +: WIDTHA] = PAD;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      lane <= '0;
    end else if (accept) begin
      acc[32'(lane)*WIDTHA +: WIDTHA] <= data;
      lane <= commit ? '0 : lane + 1'b1;
    end
  end

endmodule

// File: rtl/v_asymmetric_byte_packer.sv
// Byte-stream to wide-word packer driving the wide port of the 256x8/64x32 asymmetric RAM.
// Define ASYM_PACKER_WRAP_EN for circular-buffer operation instead of stopping when full.
module v_asymmetric_byte_packer
  import v_asymmetric_byte_packer_pkg::*;
#(
  parameter int unsigned       WIDTHA     = 8,
  parameter int unsigned       WIDTHB     = 32,
  parameter int unsigned       SIZEB      = 64,
  parameter int unsigned       ADDRWIDTHB = 6,
  parameter logic [WIDTHA-1:0] PAD        = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [WIDTHA-1:0]     s_data,
  input  logic                  s_last,
  output logic                  enB,
  output logic                  weB,
  output logic [ADDRWIDTHB-1:0] addrB,
  output logic [WIDTHB-1:0]     diB,
  output logic                  frame_done,
  output logic                  full,
  output logic [ADDRWIDTHB:0]   words_written
);

  state_t                state;
  logic [ADDRWIDTHB-1:0] word_ptr;
  logic                  accept;
  logic                  commit;
  logic                  last_word;
  logic [WIDTHB-1:0]     word;

  always_comb begin
    s_ready   = (state == FILL) & ~clr & ~rst;
    accept    = s_valid & s_ready;
    last_word = (word_ptr == ADDRWIDTHB'(SIZEB - 1));
  end

  v_asym_lane_accum #(
    .WIDTHA (WIDTHA),
    .WIDTHB (WIDTHB),
    .PAD    (PAD)
  ) u_accum (
    .clk    (clk),
    .clear  (rst | clr),
    .accept (accept),
    .last   (s_last),
    .data   (s_data),
    .commit (commit),
    .word   (word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= FILL;
      word_ptr      <= '0;
      enB           <= 1'b0;
      weB           <= 1'b0;
      addrB         <= '0;
      diB           <= '0;
      frame_done    <= 1'b0;
      full          <= 1'b0;
      words_written <= '0;
    end else begin
      enB        <= 1'b0;
      weB        <= 1'b0;
      frame_done <= 1'b0;
`ifdef ASYM_PACKER_WRAP_EN
      full       <= 1'b0;
`endif
      if (clr) begin
        state         <= FILL;
        word_ptr      <= '0;
        words_written <= '0;
        full          <= 1'b0;
      end else if (commit) begin
        enB        <= 1'b1;
        weB        <= 1'b1;
        addrB      <= word_ptr;
        diB        <= word;
        frame_done <= s_last;
        if (words_written != (ADDRWIDTHB+1)'(SIZEB))
          words_written <= words_written + 1'b1;
        if (last_word) begin
          word_ptr <= '0;
          full     <= 1'b1;
`ifndef ASYM_PACKER_WRAP_EN
          state    <= FULL;
`endif
        end else begin
          word_ptr <= word_ptr + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_v_asymmetric_byte_packer.sv
// Self-checking bench for v_asymmetric_byte_packer against a byte-queue reference model.
module tb_v_asymmetric_byte_packer;

  localparam int unsigned WA  = 8;
  localparam int unsigned WB  = 32;
  localparam int unsigned SZ  = 64;
  localparam int unsigned AW  = 6;
  localparam int unsigned R   = WB / WA;
  localparam logic [7:0]  PADV = 8'h00;
`ifdef ASYM_PACKER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, clr, s_valid, s_last;
  logic          s_ready;
  logic [WA-1:0] s_data;
  logic          enB, weB, frame_done, full;
  logic [AW-1:0] addrB;
  logic [WB-1:0] diB;
  logic [AW:0]   words_written;

  always #5 clk = ~clk;

  v_asymmetric_byte_packer #(
    .WIDTHA     (WA),
    .WIDTHB     (WB),
    .SIZEB      (SZ),
    .ADDRWIDTHB (AW),
    .PAD        (PADV)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .clr           (clr),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .s_last        (s_last),
    .enB           (enB),
    .weB           (weB),
    .addrB         (addrB),
    .diB           (diB),
    .frame_done    (frame_done),
    .full          (full),
    .words_written (words_written)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: bytes of the word in progress, buffer pointer, and expected registered outputs
  logic [7:0]  q[$];
  int unsigned m_ptr = 0, m_ww = 0;
  bit          m_stop = 1'b0;
  bit          exp_en = 1'b0, exp_fd = 1'b0, exp_full = 1'b0;
  int unsigned exp_addr = 0;
  logic [31:0] exp_di = '0;
  int unsigned obs_writes = 0;

  task automatic step(input bit v, input logic [7:0] d, input bit l, input bit c, input bit r,
                      output bit accepted);
    bit          rdy;
    logic [31:0] w, b;
    s_valid = v; s_data = d; s_last = l; clr = c; rst = r;
    #1;
    rdy = !m_stop && !c && !r;
    check("s_ready", s_ready, rdy);
    accepted = v && rdy;
    if (r) begin
      q.delete();
      m_ptr = 0; m_ww = 0; m_stop = 0;
      exp_en = 0; exp_addr = 0; exp_di = '0; exp_fd = 0; exp_full = 0;
    end else begin
      exp_en = 0; exp_fd = 0;
      if (WRAP) exp_full = 0;
      if (c) begin
        q.delete();
        m_ptr = 0; m_ww = 0; m_stop = 0; exp_full = 0;
      end else if (accepted) begin
        q.push_back(d);
        if (q.size() == R || l) begin
          w = '0;
          for (int unsigned i = 0; i < R; i++) begin
            b = (i < q.size()) ? {24'h0, q[i]} : {24'h0, PADV};
            w = w | (b << (WA * i));
          end
          q.delete();
          exp_en = 1; exp_addr = m_ptr; exp_di = w; exp_fd = l;
          if (m_ww < SZ) m_ww++;
          m_ptr++;
          if (m_ptr == SZ) begin
            m_ptr = 0;
            exp_full = 1;
            if (!WRAP) m_stop = 1;
          end
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (weB) obs_writes++;
    check("enB", enB, exp_en);
    check("weB", weB, exp_en);
    check("addrB", addrB, exp_addr);
    check("diB", diB, exp_di);
    check("frame_done", frame_done, exp_fd);
    check("full", full, exp_full);
    check("words_written", words_written, m_ww);
  endtask

  initial begin
    bit          acc;
    int unsigned nacc, budget;
    rst = 1; clr = 0; s_valid = 0; s_data = '0; s_last = 0;
    @(negedge clk);
    step(0, 8'h00, 0, 0, 1, acc);
    step(0, 8'h00, 0, 0, 1, acc);
    check("rst_weB", weB, 0);
    check("rst_diB", diB, 0);
    check("rst_ww", words_written, 0);

    // Four bytes back-to-back pack little-endian into word 0, next word goes to 1
    step(1, 8'h11, 0, 0, 0, acc);
    step(1, 8'h22, 0, 0, 0, acc);
    step(1, 8'h33, 0, 0, 0, acc);
    step(1, 8'h44, 0, 0, 0, acc);
    check("d1_weB", weB, 1);
    check("d1_addrB", addrB, 0);
    check("d1_diB", diB, 32'h44332211);
    for (int unsigned i = 0; i < 4; i++) step(1, 8'(8'h55 + 8'h11 * i), 0, 0, 0, acc);
    check("d1_next_addrB", addrB, 1);

    // Short frame padded
    step(0, 8'h00, 0, 1, 0, acc);
    step(1, 8'hAA, 0, 0, 0, acc);
    step(1, 8'hBB, 1, 0, 0, acc);
    check("d2_diB", diB, 32'h0000BBAA);
    check("d2_addrB", addrB, 0);
    check("d2_fd", frame_done, 1);

    // clr mid-word with s_valid high discards partial word
    step(1, 8'hC1, 0, 0, 0, acc);
    step(1, 8'hC2, 0, 0, 0, acc);
    step(1, 8'hC3, 0, 1, 0, acc);
    check("d3_no_write", weB, 0);
    check("d3_ww", words_written, 0);
    for (int unsigned i = 1; i <= 4; i++) step(1, 8'(i), 0, 0, 0, acc);
    check("d3_diB", diB, 32'h04030201);
    check("d3_addrB", addrB, 0);

    // rst right after a commit cancels everything
    for (int unsigned i = 0; i < 4; i++) step(1, 8'(8'hE0 + i), 0, 0, 0, acc);
    step(1, 8'h99, 0, 0, 1, acc);
    check("d4_weB", weB, 0);
    check("d4_addrB", addrB, 0);

    // Random mixed traffic
    for (int unsigned i = 0; i < 300; i++)
      step($urandom_range(3) != 0, 8'($urandom), $urandom_range(7) == 0,
           $urandom_range(39) == 0, 1'b0, acc);

    // Fill the whole buffer with gappy traffic, then push four extra bytes
    step(0, 8'h00, 0, 0, 1, acc);
    obs_writes = 0;
    nacc = 0;
    budget = 0;
    while (nacc < 256 && budget < 2000) begin
      step($urandom_range(2) != 0, 8'($urandom), 0, 0, 0, acc);
      if (acc) nacc++;
      budget++;
    end
    check("fill_accepted", nacc, 256);
    check("fill_writes", obs_writes, 64);
    check("fill_ww", words_written, 64);
`ifndef ASYM_PACKER_WRAP_EN
    check("fill_full", full, 1);
    check("fill_ready", s_ready, 0);
`endif
    for (int unsigned i = 0; i < 4; i++) step(1, 8'(8'hF0 + i), 0, 0, 0, acc);
`ifdef ASYM_PACKER_WRAP_EN
    check("wrap_writes", obs_writes, 65);
    check("wrap_addrB", addrB, 0);
    check("wrap_diB", diB, 32'hF3F2F1F0);
`else
    check("stop_writes", obs_writes, 64);
`endif
    check("sat_ww", words_written, 64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/v_asymmetric_byte_packer.md
Name: v_asymmetric_byte_packer

Overview:
- Upstream write-side stage for the 256x8 / 64x32 asymmetric dual-port RAM.
- Accepts a byte stream over a valid/ready handshake and packs RATIO bytes into one wide word.
- Drives the RAM's wide port (enB/weB/addrB/diB) with sequential word addresses.
- Byte n of a frame lands at narrow-port address n, so port A can read the frame back byte-for-byte.

Parameters:
- WIDTHA, 8, narrow (input byte) width
- WIDTHB, 32, wide word width; must be an integer multiple of WIDTHA
- SIZEB, 64, wide-port depth in words
- ADDRWIDTHB, 6, wide-port address width; log2(SIZEB)
- PAD, 0, value written into unfilled lanes of a partial final word (WIDTHA bits)

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- clr  in  1  synchronous frame restart: pointer to 0, lane to 0, leave FULL
- s_valid  in  1  input byte valid
- s_ready  out  1  block can accept a byte
- s_data  in  WIDTHA  input byte
- s_last  in  1  final byte of frame
- enB  out  1  RAM wide-port enable
- weB  out  1  RAM wide-port write enable
- addrB  out  ADDRWIDTHB  RAM word address
- diB  out  WIDTHB  RAM write data
- frame_done  out  1  one-cycle pulse coincident with a frame's last write
- full  out  1  buffer exhausted
- words_written  out  ADDRWIDTHB+1  words written since rst/clr; saturates at SIZEB

Behaviour:
- One clock; reset is synchronous and active-high.
- Derived constants: RATIO = WIDTHB/WIDTHA; LANEW = log2(RATIO).
- Reset values: enB=0, weB=0, addrB=0, diB=0, frame_done=0, full=0, words_written=0, lane=0, word_ptr=0, state=FILL.
- s_ready = (state==FILL) & ~clr & ~rst (combinational). A byte is accepted when s_valid & s_ready.
- States: FILL, FULL.
- Accept in FILL with lane<RATIO-1 and ~s_last:
  - Byte stored at accumulator bits [(lane+1)*WIDTHA-1 : lane*WIDTHA].
  - lane increments.
- Accept with lane==RATIO-1 or s_last (word commit):
  - Next cycle: enB=weB=1 for exactly one cycle.
  - addrB=word_ptr; diB=accumulated lanes plus the current byte.
  - Lanes above the current one are filled with PAD.
  - lane resets to 0; word_ptr and words_written increment.
  - frame_done pulses in the same cycle as the write when s_last was set.
- Write latency: 1 cycle from commit accept to weB.
- Throughput: 1 byte/cycle. The byte accepted during the write cycle starts a new word in lane 0.
- enB/weB are 0 in all cycles without a write; diB/addrB hold their last values.
- Boundary, commit at word_ptr==SIZEB-1: word is written, word_ptr wraps to 0, state becomes FULL on the next edge. s_ready deasserts in the write cycle itself.
- FULL:
  - s_ready=0, full=1, no writes.
  - Exit only via clr or rst, both returning to FILL with pointer 0.
- clr mid-word: partially accumulated bytes are discarded and nothing is written. A write already registered from the prior cycle still completes. words_written=0 the cycle after clr.
- clr and s_valid in the same cycle: clr wins, the byte is not accepted (s_ready=0).
- rst mid-operation: same as clr, and additionally the pending registered write is cancelled (weB=0 next cycle).
- words_written saturates at SIZEB and never wraps.

Optional Feature:
- Macro: ASYM_PACKER_WRAP_EN
- Defined: circular buffer. No FULL state; after SIZEB-1 word_ptr wraps to 0 and packing continues. full pulses for one cycle with each wrap write. words_written still saturates.
- Undefined: FULL-state behaviour as above.

Decomposition:
- Shared package holds:
  - localparams RATIO and LANEW
  - the log2 function (same semantics as the RAM's)
  - state encoding FILL=1'b0, FULL=1'b1
- Natural sub-module: v_asym_lane_accum.
  - Lane counter plus accumulator register.
  - Inputs: accept, last, clear, byte.
  - Outputs: commit strobe and packed word with PAD fill.
- Top holds the FSM, word pointer, counters and registered RAM-port outputs.

Test Plan:
- Bytes 0x11,0x22,0x33,0x44 back-to-back -> one cycle after 4th accept: weB=1, addrB=0, diB=0x44332211; next word goes to addrB=1.
- Bytes 0xAA,0xBB with s_last on 0xBB, PAD=0 -> diB=0x0000BBAA, addrB=0, frame_done=1 in the same cycle as weB.
- 256 bytes with random s_valid gaps -> exactly 64 writes, addrB 0..63 in order, full=1, s_ready=0, words_written=64. Extra s_valid produces no write.
- Same 256+4 bytes with ASYM_PACKER_WRAP_EN -> 65th write at addrB=0, full pulses once, never stalls.
- 2 bytes, then clr with s_valid=1 -> no write, clr-cycle byte rejected. Next 4 bytes 0x01..0x04 -> diB=0x04030201 at addrB=0.
- rst asserted in the cycle after a 4th-byte accept -> weB stays 0, all outputs at reset values next cycle.
